inst_mem_responder: RTL

Instruction-memory responder that sits on the far side of the fetch stage's memory port. It answers single-word fetch reads with a fixed one-cycle latency. Before execution it is programmed through a byte-serial boot-load stream that it packs into 16-bit words. It owns the instruction storage and the boot/run state, so the fetch stage only ever sees a simple request/response memory.

---
 rtl/inst_mem_pkg.sv | 14 +
 rtl/inst_mem_responder_if.sv | 31 +++
 rtl/inst_mem_responder_byte_packer.sv | 38 +++
 rtl/inst_mem_responder.sv | 119 +++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package inst_mem_pkg;

   localparam int ADDR_W_DEFAULT = 10;
   localparam logic [15:0] OOB_FILL = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      RUN
   } state_t;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response port and byte-serial boot-load port of the responder.
interface inst_mem_responder_if;

   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ready;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [15:0] rsp_addr;
   logic        rsp_oob;
   logic        load_start;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic        load_ready;
   logic        load_overflow;
   logic        loading;

   modport master (
      output fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last,
      input  fetch_ready, rsp_valid, rsp_data, rsp_addr, rsp_oob,
             load_ready, load_overflow, loading
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last,
      output fetch_ready, rsp_valid, rsp_data, rsp_addr, rsp_oob,
             load_ready, load_overflow, loading
   );

endinterface

// File: rtl/inst_mem_responder_byte_packer.sv
// Packs boot bytes low-first into 16-bit words; pads a dangling low byte on flush.
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   input  logic        flush,
   output logic        word_valid,
   output logic [15:0] word
);

   logic       half;
   logic [7:0] low;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half <= 1'b0;
         low  <= 8'h00;
      end else if (clear) begin
         half <= 1'b0;
      end else if (byte_valid) begin
         if (!half) begin
            low  <= byte_in;
            half <= 1'b1;
         end else begin
            half <= 1'b0;
         end
      end else if (flush) begin
         half <= 1'b0;
      end
   end

   // A word completes either on its high byte or on a flush with a pending low byte.
   assign word_valid = half && (byte_valid || flush);
   assign word       = byte_valid ? {byte_in, low} : {8'h00, low};

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory with boot-load packing and one-cycle-latency fetch responses.
module inst_mem_responder
   import inst_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   inst_mem_responder_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   state_t              state;
   state_t              state_nx;
   logic                start;
   logic                byte_acc;
   logic                fetch_acc;
   logic                addr_oob;
   logic                word_valid;
   logic [15:0]         word;
   logic [ADDR_W-1:0]   wptr;
   logic                overflow;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   mem_q;
   logic                rsp_valid_q;
   logic                rsp_oob_q;
   logic [15:0]         rsp_addr_q;

   // FLUSH always completes, so a start there is ignored; start beats any byte or fetch.
   assign start     = bus.load_start && (state != FLUSH);
   assign byte_acc  = (state == LOAD) && bus.load_valid && !bus.load_start;
   assign fetch_acc = (state == RUN) && bus.fetch_req && !bus.load_start;
   assign addr_oob  = |bus.fetch_addr[15:ADDR_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx        = state;
      bus.load_ready  = 1'b0;
      bus.fetch_ready = 1'b0;
      bus.loading     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = LOAD;
         end
         LOAD: begin
            bus.load_ready = 1'b1;
            bus.loading    = 1'b1;
            if (start)                          state_nx = LOAD;
            else if (byte_acc && bus.load_last) state_nx = FLUSH;
         end
         FLUSH: begin
            bus.loading = 1'b1;
            state_nx    = RUN;
         end
         RUN: begin
            bus.fetch_ready = 1'b1;
            if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start),
      .byte_valid (byte_acc),
      .byte_in    (bus.load_byte),
      .flush      (state == FLUSH),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         overflow <= 1'b0;
      end else if (start) begin
         wptr     <= '0;
         overflow <= 1'b0;
      end else if (word_valid) begin
         wptr <= wptr + 1'b1;
         if (wptr == {ADDR_W{1'b1}}) overflow <= 1'b1;
      end
   end

   // Writes only happen in LOAD/FLUSH and reads only in RUN, so the ports never collide.
   always_ff @(posedge clk) begin
      if (word_valid) mem[wptr] <= DATA_W'(word);
      if (fetch_acc)  mem_q     <= mem[bus.fetch_addr[ADDR_W-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_oob_q   <= 1'b0;
         rsp_addr_q  <= 16'h0000;
      end else begin
         rsp_valid_q <= fetch_acc;
         if (fetch_acc) begin
            rsp_oob_q  <= addr_oob;
            rsp_addr_q <= bus.fetch_addr;
         end
      end
   end

   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_addr      = rsp_addr_q;
   assign bus.rsp_oob       = rsp_valid_q && rsp_oob_q;
   assign bus.rsp_data      = (rsp_valid_q && !rsp_oob_q) ? 16'(mem_q) : OOB_FILL;
   assign bus.load_overflow = overflow;

endmodule
